dds_wave_reader: RTL
====================

# dds_wave_reader

Phase-accumulator read master for the single-port waveform ROM (`rom_wave`) in the DSO signal-generator path. It issues one ROM address per cycle, tracks the ROM's fixed read latency with a tag pipeline, and lands returned samples in a small output FIFO. The FIFO presents them as a valid/ready sample stream to the DAC/display path. Frequency, phase offset and waveform changes are shadowed and take effect only at a period boundary, so the output is glitch-free.

## Interface
- `PHASE_WIDTH`, 32, phase accumulator width.
- `ADDR_WIDTH`, 10, samples-per-wave address bits (ROM table length 2^ADDR_WIDTH).
- `WAVE_BITS`, 2, waveform-select bits; ROM address width = WAVE_BITS+ADDR_WIDTH.
- `DATA_WIDTH`, 8, sample width.
- `ROM_LATENCY`, 2, ROM read latency in cycles (1 = no output reg, 2 = output reg); legal 1..2.
- `FIFO_DEPTH`, 4, output FIFO depth; must be >= ROM_LATENCY+2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run request; level.
- `cfg_load`  in  1  one-cycle pulse; captures `freq_word`, `phase_ofs`, `wave_sel` into the shadow registers.
- `freq_word`  in  PHASE_WIDTH  phase increment per sample.
- `phase_ofs`  in  ADDR_WIDTH  address offset added to the accumulator MSBs.
- `wave_sel`  in  WAVE_BITS  waveform table select.
- `rom_addr`  out  WAVE_BITS+ADDR_WIDTH  ROM address; ROM is wired with clk_en=1, addr_strobe=0, rd_oce=1.
- `rom_rd_data`  in  DATA_WIDTH  ROM read data.
- `m_data`  out  DATA_WIDTH  sample at FIFO head.
- `m_last`  out  1  marks the last sample of a waveform period.
- `m_valid`  out  1  FIFO non-empty.
- `m_ready`  in  1  sink accepts the sample; a transfer occurs when `m_valid && m_ready`.
- `busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE: no reads issued. Moves to RUN when `en`=1.
  - RUN: a read is issued in any cycle where `en`=1 and `occ + inflight < FIFO_DEPTH`. Both counts are the registered current-cycle values; a same-cycle pop is not credited. When `en` drops, the FSM moves to DRAIN.
  - DRAIN: no reads issued. Moves to IDLE when `inflight`=0. FIFO contents are retained and remain poppable in every state.
- Issue cycle:
  - `rom_addr` = {wave_act, acc[PHASE_WIDTH-1 -: ADDR_WIDTH] + ofs_act}. The add is modulo 2^ADDR_WIDTH.
  - acc <= acc + freq_act, modulo 2^PHASE_WIDTH.
  - The carry out of that add is the period-wrap flag. It is pushed with the tag and becomes `m_last` for this sample.
- Tag pipeline: a ROM_LATENCY-deep shift register of {valid, wrap}. When a valid tag exits, `rom_rd_data` and the wrap flag are written into the FIFO. `inflight` = number of valid tags.
- Shadow config:
  - `cfg_load` sets `pend` and overwrites the shadow registers (last load wins).
  - Active registers take the shadow values, and `pend` clears, on either of:
    - an issue cycle whose wrap flag = 1 (the new values apply from the next issue);
    - any cycle in IDLE.
  - When config is applied in IDLE, acc is cleared to 0. A wrap-boundary apply does not clear acc.
- Stop/restart: acc is held across RUN→DRAIN→IDLE unless a pending config is applied in IDLE.
- Reset: clears acc, active and shadow config (all 0), `pend`, tags, and the FIFO.
- Outputs after reset: `m_valid`=0, `m_last`=0, `m_data`=0, `rom_addr`=0, `busy`=0. State = IDLE.
- `rst` mid-operation discards in-flight reads. Data returned by the ROM afterwards is ignored because the tags are cleared.

## Timing
- `en` rises at cycle t: RUN from t+1, first issue at t+1.
  - First sample write into the FIFO at t+1+ROM_LATENCY; `m_valid`=1 at t+2+ROM_LATENCY.
- Steady state with `m_ready`=1: one sample per cycle, no bubbles. FIFO_DEPTH >= ROM_LATENCY+2 guarantees this.
- With `m_ready`=0, issue stops once occ+inflight reaches FIFO_DEPTH. The FIFO never overflows, and no ROM data is dropped.
- FIFO:
  - First-word-fall-through; `m_data`/`m_last` are valid whenever `m_valid`=1.
  - Simultaneous push and pop on a full FIFO is legal; occ is unchanged.
  - Pop on empty is ignored.
- `cfg_load` in the same cycle as a wrap issue: the shadow captures the new value, which is applied at the following wrap, not this one.

## Test plan
- Reset: hold `rst` 3 cycles with `en`=1 -> all outputs 0, `busy`=0; the first `m_valid` appears exactly ROM_LATENCY+2 cycles after `rst` falls.
- Ramp table, wave 0: `freq_word`=2^22, `phase_ofs`=0, `m_ready`=1 -> addresses 0,1,2…1023,0 on consecutive cycles; `m_last`=1 only on the address-1023 sample; 1024 samples per period.
- Offset/select: `phase_ofs`=1020, `wave_sel`=2, then `cfg_load` while IDLE -> first address {2,1020}, then 1021,1022,1023,0 (wrap-around of the offset add).
- Boundary switch: in RUN at `freq_word`=2^22, load `freq_word`=2^23 mid-period -> step stays 1 until the `m_last` sample, then step 2 (0,2,4…); no sample lost or duplicated.
- Backpressure: random `m_ready` (50%) for 5000 cycles -> output sequence identical to the `m_ready`=1 reference; occ never exceeds FIFO_DEPTH.
- Stop/reset mid-run: drop `en` with 2 reads in flight -> both land, `busy` falls after ROM_LATENCY cycles. Separately, assert `rst` with reads in flight -> FIFO empty and no stale sample appears.

Source files
------------

// File: rtl/dds_wave_reader.sv
// dds_wave_reader
// Phase-accumulator read master for the waveform ROM. Issues one ROM address
// per cycle while running, tracks the ROM read latency with a tag pipeline and
// lands returned samples in a small first-word-fall-through output FIFO.
// Frequency / offset / waveform changes are shadowed and applied only at a
// period wrap (or while idle) so the output never glitches mid-period.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run request (level)
//   cfg_load      one-cycle pulse capturing freq_word/phase_ofs/wave_sel
//   rom_addr      {wave, table index} address to the ROM
//   rom_rd_data   ROM read data, ROM_LATENCY cycles after rom_addr
//   m_data/m_last/m_valid/m_ready  output sample stream (m_last = period end)
//   busy          FSM not idle
module dds_wave_reader #(
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAVE_BITS   = 2,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ROM_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic                            cfg_load,
  input  logic [PHASE_WIDTH-1:0]          freq_word,
  input  logic [ADDR_WIDTH-1:0]           phase_ofs,
  input  logic [WAVE_BITS-1:0]            wave_sel,
  output logic [WAVE_BITS+ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]           rom_rd_data,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + ROM_LATENCY + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  acc_q, acc_d;
  logic [PHASE_WIDTH-1:0]  freq_act_q, freq_act_d, freq_shd_q, freq_shd_d;
  logic [ADDR_WIDTH-1:0]   ofs_act_q, ofs_act_d, ofs_shd_q, ofs_shd_d;
  logic [WAVE_BITS-1:0]    wave_act_q, wave_act_d, wave_shd_q, wave_shd_d;
  logic                    pend_q, pend_d;
  logic [ROM_LATENCY-1:0]  tag_vld_q, tag_vld_d, tag_wrap_q, tag_wrap_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [FIFO_DEPTH];
  logic                    last_q [FIFO_DEPTH];
  logic                    last_d [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        occ_q, occ_d;

  logic [CNT_W-1:0]        inflight;
  logic [PHASE_WIDTH:0]    acc_sum;
  logic [ADDR_WIDTH-1:0]   tbl_idx;
  logic                    wrap, issue, apply, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_vld_q[i]);
    end
  end

  assign acc_sum  = {1'b0, acc_q} + {1'b0, freq_act_q};
  assign wrap     = acc_sum[PHASE_WIDTH];
  assign tbl_idx  = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH] + ofs_act_q;
  assign rom_addr = {wave_act_q, tbl_idx};

  // Credit only registered occupancy + in-flight reads: a same-cycle pop is
  // not counted, which keeps the FIFO from ever overflowing.
  assign issue = (state_q == ST_RUN) && en && ((occ_q + inflight) < CNT_W'(FIFO_DEPTH));
  assign apply = pend_q && ((state_q == ST_IDLE) || (issue && wrap));
  assign push  = tag_vld_q[ROM_LATENCY-1];
  assign pop   = (occ_q != '0) && m_ready;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    freq_act_d = freq_act_q;
    ofs_act_d  = ofs_act_q;
    wave_act_d = wave_act_q;
    freq_shd_d = freq_shd_q;
    ofs_shd_d  = ofs_shd_q;
    wave_shd_d = wave_shd_q;
    pend_d     = pend_q;
    mem_d      = mem_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q + CNT_W'(push) - CNT_W'(pop);

    // Apply uses the pre-load shadow; a load in the same cycle stays pending
    // for the next boundary.
    if (apply) begin
      freq_act_d = freq_shd_q;
      ofs_act_d  = ofs_shd_q;
      wave_act_d = wave_shd_q;
      pend_d     = 1'b0;
    end
    if (cfg_load) begin
      freq_shd_d = freq_word;
      ofs_shd_d  = phase_ofs;
      wave_shd_d = wave_sel;
      pend_d     = 1'b1;
    end

    if (issue) begin
      acc_d = acc_sum[PHASE_WIDTH-1:0];
    end else if (apply) begin
      acc_d = '0;
    end

    tag_vld_d     = tag_vld_q;
    tag_wrap_d    = tag_wrap_q;
    tag_vld_d[0]  = issue;
    tag_wrap_d[0] = issue && wrap;
    for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
      tag_vld_d[i]  = tag_vld_q[i-1];
      tag_wrap_d[i] = tag_wrap_q[i-1];
    end

    if (push) begin
      mem_d[wr_ptr_q]  = rom_rd_data;
      last_d[wr_ptr_q] = tag_wrap_q[ROM_LATENCY-1];
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: if (inflight == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      freq_act_q <= '0;
      ofs_act_q  <= '0;
      wave_act_q <= '0;
      freq_shd_q <= '0;
      ofs_shd_q  <= '0;
      wave_shd_q <= '0;
      pend_q     <= 1'b0;
      tag_vld_q  <= '0;
      tag_wrap_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]  <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      freq_act_q <= freq_act_d;
      ofs_act_q  <= ofs_act_d;
      wave_act_q <= wave_act_d;
      freq_shd_q <= freq_shd_d;
      ofs_shd_q  <= ofs_shd_d;
      wave_shd_q <= wave_shd_d;
      pend_q     <= pend_d;
      tag_vld_q  <= tag_vld_d;
      tag_wrap_q <= tag_wrap_d;
      mem_q      <= mem_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  assign m_data  = mem_q[rd_ptr_q];
  assign m_last  = last_q[rd_ptr_q];
  assign m_valid = (occ_q != '0);
  assign busy    = (state_q != ST_IDLE);

endmodule
